// File: rtl/button_conditioner_if.sv
// Button-side signal bundle for button_conditioner: raw input plus the conditioned outputs.
// master drives the raw button; slave is the conditioner itself.
interface button_conditioner_if;
  logic       btn_in;
  logic       btn_level;
  logic       btn_pulse;
  logic [1:0] state_o;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_pulse,
    input  state_o
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_pulse,
    output state_o
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces a raw push-button into a clean level and a one-cycle press pulse.
// Optional macro BUTTON_CONDITIONER_AUTO_REPEAT_EN: a held button re-pulses every REPEAT_CYCLES cycles.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8,
  parameter int CNT_W           = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  button_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    ARM_PRESS   = 2'b01,
    PRESSED     = 2'b10,
    ARM_RELEASE = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`else
  localparam int unused_repeat_cycles = REPEAT_CYCLES;
`endif

  logic             sync0_q, sync1_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             cnt_last;

  assign cnt_last = (cnt_q == DEB_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync0_q <= bus.btn_in;
      sync1_q <= sync0_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (sync1_q) state_d = ARM_PRESS;
      ARM_PRESS:   if (!sync1_q) state_d = IDLE;
                   else if (cnt_last) state_d = PRESSED;
      PRESSED:     if (!sync1_q) state_d = ARM_RELEASE;
      ARM_RELEASE: if (sync1_q) state_d = PRESSED;
                   else if (cnt_last) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Counter clears on every state change; level only moves when an arming phase completes.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (state_d != state_q) begin
      if (state_q == ARM_PRESS && state_d == PRESSED) begin
        level_d = 1'b1;
        pulse_d = 1'b1;
      end else if (state_q == ARM_RELEASE && state_d == IDLE) begin
        level_d = 1'b0;
      end
    end else begin
      case (state_q)
        ARM_PRESS, ARM_RELEASE: cnt_d = cnt_q + 1'b1;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        PRESSED: begin
          if (cnt_q == REP_LAST) pulse_d = 1'b1;
          else                   cnt_d   = cnt_q + 1'b1;
        end
`endif
        default: cnt_d = '0;
      endcase
    end
  end

  assign bus.btn_level = level_q;
  assign bus.btn_pulse = pulse_q;
  assign bus.state_o   = state_q;

endmodule
